// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: state encodings, reset PC, instruction width,
// NOP encoding and the {pc, instr, valid} entry carried toward decode.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            valid;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_stage_hold_buf.sv
// Stall capture buffer: latches the instruction on display when a stall begins
// so it survives the memory moving on underneath it.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         capture_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o
);

  fetch_entry_t entry_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          entry_q <= '0;
    else if (capture_i) entry_q <= entry_i;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage_reg.sv
// Generic enabled register with asynchronous active-high reset to RST_VAL.
module fetch_stage_reg #(
  parameter int unsigned   W       = 32,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem,
// holds across stalls and squashes on redirect. `FETCH_PERF_EN adds perf counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_data,
  output logic [XLEN-1:0] pc_out,
  output logic [ILEN-1:0] instr_out,
  output logic            valid_out,
  output logic            flush_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q;
  logic            pend_v_q;
  logic            adv;
  logic            capture;
  fetch_entry_t    run_entry, hold_entry, cur_entry;

  // The whole front end advances together; redirect overrides a stall.
  assign adv        = ~stall | redirect;
  assign fetch_pc_d = redirect ? redirect_pc : pc_next(fetch_pc_q, PC_STEP);

  fetch_stage_reg #(
    .W       (XLEN),
    .RST_VAL (RESET_PC)
  ) u_fetch_pc (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (adv),
    .d_i   (fetch_pc_d),
    .q_o   (fetch_pc_q)
  );

  assign imem_addr = fetch_pc_q;

  // pend_* tracks which address the imem data belongs to. Since fetch_pc is
  // frozen during a hold, the release cycle re-reads the same address and the
  // following instruction lands aligned with no gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_pc_q <= '0;
      pend_v_q  <= 1'b0;
    end else if (adv) begin
      pend_pc_q <= fetch_pc_q;
      pend_v_q  <= ~redirect;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE: if (adv) state_d = FS_RUN;
      FS_RUN:  if (stall && !redirect) state_d = FS_HOLD;
      FS_HOLD: if (adv) state_d = FS_RUN;
      default: state_d = FS_IDLE;
    endcase
  end

  assign run_entry = '{pc: pend_pc_q, instr: imem_data, valid: pend_v_q};
  assign capture   = (state_q == FS_RUN) & stall & ~redirect;

  fetch_hold_buf u_hold (
    .clk_i     (clk),
    .rst_i     (rst),
    .capture_i (capture),
    .entry_i   (run_entry),
    .entry_o   (hold_entry)
  );

  always_comb begin
    cur_entry = '0;
    case (state_q)
      FS_RUN:  cur_entry = run_entry;
      FS_HOLD: cur_entry = hold_entry;
      default: cur_entry = '0;
    endcase
  end

  // A redirect squashes whatever is on display this cycle.
  assign valid_out = cur_entry.valid & ~redirect;
  assign instr_out = valid_out ? cur_entry.instr : NOP_INSTR;
  assign pc_out    = cur_entry.pc;
  assign flush_out = ~valid_out;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (valid_out && !stall && perf_fetched_q != 32'hFFFF_FFFF)
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (!valid_out && perf_bubbles_q != 32'hFFFF_FFFF)
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the fetch-to-decode pipeline register.
- Owns the PC and drives the synchronous instruction memory (1-cycle read latency).
- Holds returned instructions across stalls and inserts bubbles on redirect.
- Presents {PC, instruction, valid} each cycle for capture by the F/D register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first address issued to imem.
- PC_STEP, 1, PC increment per sequential fetch (word-addressed imem).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit hold: freeze PC and outputs (same sense as the F/D register's !enable).
- redirect  in  1  taken branch/jump from execute; load redirect_pc.
- redirect_pc  in  32  redirect target.
- imem_addr  out  32  instruction memory address (= fetch PC register).
- imem_data  in  32  instruction memory read data; corresponds to the address of the previous cycle.
- pc_out  out  32  PC of the instruction on instr_out (to F/D PCIn).
- instr_out  out  32  instruction (to F/D instructionIn).
- valid_out  out  1  instr_out/pc_out are a real instruction.
- flush_out  out  1  bubble request to F/D (= !valid_out).

Behaviour:
- Registers:
  - fetch_pc: address being issued.
  - pend_pc: address issued last cycle.
  - pend_v: the imem response this cycle is wanted.
  - hold_instr / hold_pc: captured during a stall.
  - state.
- Reset (async):
  - fetch_pc=RESET_PC, pend_pc=0, pend_v=0, state=IDLE.
  - pc_out=0, instr_out=0, valid_out=0, flush_out=1.
- States:
  - IDLE: first cycle after reset deassertion. Issue RESET_PC; pend_v<=1; go to RUN.
  - RUN:
    - Outputs: pc_out=pend_pc, instr_out=imem_data, valid_out=pend_v.
    - No stall and no redirect: fetch_pc<=fetch_pc+PC_STEP (32-bit, wraps modulo 2^32); pend_pc<=fetch_pc; pend_v<=1.
  - HOLD:
    - Entered from RUN when stall=1 and redirect=0. Capture hold_pc<=pend_pc, hold_instr<=imem_data, hold_v<=pend_v.
    - fetch_pc is frozen while in HOLD.
    - Outputs come from the hold registers.
    - On stall=0: return to RUN, issuing fetch_pc+PC_STEP and presenting the held instruction for its final cycle. Release latency: the held instruction is consumed in the release cycle; the next instruction appears the cycle after, with no gap.
  - Re-fetch rule: while in HOLD, imem_addr=pend_pc is re-issued on the release cycle, so the data arrives aligned. Implementer may choose either scheme, but the no-gap property is mandatory.
- Redirect:
  - Highest priority: beats stall in every state.
  - Same cycle: valid_out=0 (wrong-path instruction squashed), flush_out=1.
  - Next edge: fetch_pc<=redirect_pc, pend_v<=0, state<=RUN.
  - The first target instruction appears with valid_out=1 two cycles after redirect is asserted.
- Back-to-back redirects: the latest target wins; no valid output in between.
- Redirect during IDLE: target replaces RESET_PC.
- Reset mid-stall or mid-redirect: all state discarded; restart from IDLE.
- flush_out is always !valid_out (combinational).

Optional Feature:
- Macro FETCH_PERF_EN adds outputs perf_fetched[31:0] and perf_bubbles[31:0]:
  - perf_fetched counts cycles with valid_out=1 and stall=0.
  - perf_bubbles counts cycles with valid_out=0.
  - Both are cleared by rst and saturate at 32'hFFFF_FFFF.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared include processor_defs:
  - State encodings FS_IDLE/FS_RUN/FS_HOLD (2-bit).
  - RESET_PC default.
  - Instruction width 32.
  - NOP encoding 32'h0, used for instr_out when invalid.
- fetch_pc is an instance of the existing register module (enable = !stall | redirect).
- Sub-module: fetch_hold_buf, the stall capture buffer (pc, instr, valid).

Test Plan:
- Reset release, no stall/redirect:
  - imem_addr sequence 0,1,2,3.
  - valid_out first high 1 cycle after IDLE, with pc_out=0 and instr_out=mem[0].
  - Thereafter pc_out increments by 1 per cycle.
- Stall held 3 cycles while pc_out=5:
  - pc_out=5, instr_out=mem[5], valid_out=1 for all 3 cycles.
  - After release: pc_out=6 next cycle, no gap or duplicate.
- Redirect to 0x40 while pc_out=8:
  - valid_out=0 that cycle and the next.
  - Then pc_out=0x40, instr_out=mem[0x40], continuing 0x41.
- Redirect and stall asserted together:
  - Redirect wins; sequence identical to the previous scenario.
- Async rst pulse mid-HOLD:
  - Outputs go to 0 and flush_out=1 immediately.
  - Restart from RESET_PC.
- PC wrap:
  - Redirect to 32'hFFFF_FFFF; next pc_out is 32'h0000_0000.
  - With FETCH_PERF_EN, counters match the counted valid and bubble cycles.
